// File: rtl/hc_sr04_ping_scheduler.sv
// Round-robin scheduler for several HC-SR04 ultrasound sensors: only one sensor ranges at a time,
// each ping is trigger pulse, echo measurement with timeout, then a quiet guard gap.
module hc_sr04_ping_scheduler #(
    parameter int unsigned CLK_FREQ         = 100000000,
    parameter int unsigned N_SENSORS        = 4,
    parameter int unsigned TRIG_DURATION_US = 10,
    parameter int unsigned ECHO_TIMEOUT_US  = 25000,
    parameter int unsigned GUARD_US         = 5000,
    parameter int unsigned O_WL             = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_enable,
    input  logic [N_SENSORS-1:0]          i_sensor_mask,
    output logic [N_SENSORS-1:0]          sn_trigger,
    input  logic [N_SENSORS-1:0]          sn_echo,
    output logic                          o_valid,
    output logic [$clog2(N_SENSORS)-1:0]  o_sensor_id,
    output logic [O_WL-1:0]               o_edge_ticks,
    output logic                          o_timeout,
    output logic                          o_busy
);

    // 64-bit arithmetic: the default timeout (25 ms at 100 MHz) overflows 32 bits before the divide.
    localparam longint unsigned TRIG_CNT  = 64'(TRIG_DURATION_US) * 64'(CLK_FREQ) / 64'd1000000;
    localparam longint unsigned TMO_CNT   = 64'(ECHO_TIMEOUT_US) * 64'(CLK_FREQ) / 64'd1000000;
    localparam longint unsigned GUARD_CNT = 64'(GUARD_US) * 64'(CLK_FREQ) / 64'd1000000;
    localparam longint unsigned CNT_MAX   = (TRIG_CNT > GUARD_CNT) ? TRIG_CNT : GUARD_CNT;

    localparam int TMO_WL = $clog2(TMO_CNT + 1);
    localparam int CW     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int IDW    = $clog2(N_SENSORS);

    localparam logic [CW-1:0]     TRIG_LAST  = CW'(TRIG_CNT - 1);
    localparam logic [CW-1:0]     GUARD_LAST = CW'(GUARD_CNT - 1);
    localparam logic [TMO_WL-1:0] TMO_LIMIT  = TMO_WL'(TMO_CNT);

    if (N_SENSORS < 2) begin : g_bad_nsensors
        $error("hc_sr04_ping_scheduler: N_SENSORS must be at least 2");
    end
    if (O_WL < TMO_WL) begin : g_bad_owl
        $error("hc_sr04_ping_scheduler: O_WL must be at least TMO_WL");
    end
    if (TRIG_CNT < 1 || TMO_CNT < 1 || GUARD_CNT < 1) begin : g_bad_times
        $error("hc_sr04_ping_scheduler: trigger, timeout and guard must each be at least one clock");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GUARD
    } state_t;

    state_t                state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [TMO_WL-1:0]     timer_q,     timer_d;
    logic [TMO_WL-1:0]     ticks_q,     ticks_d;
    logic [IDW-1:0]        sel_q,       sel_d;
    logic [IDW-1:0]        ptr_q,       ptr_d;
    logic [N_SENSORS-1:0]  trig_q,      trig_d;
    logic                  valid_q,     valid_d;
    logic [IDW-1:0]        sensorId_q,  sensorId_d;
    logic [O_WL-1:0]       edgeTicks_q, edgeTicks_d;
    logic                  timeout_q,   timeout_d;

    logic [N_SENSORS-1:0]  echoMeta_q;
    logic [N_SENSORS-1:0]  echoSync_q;
    logic                  echoPrev_q;

    logic                  echoSel;
    logic                  echoRise;
    logic [TMO_WL-1:0]     timerInc;
    logic [N_SENSORS-1:0]  maskRot;
    logic                  pickFound;
    logic [IDW-1:0]        pickIdx;
    int                    pickSum;

    assign echoSel  = echoSync_q[sel_q];
    assign echoRise = echoSel && !echoPrev_q;
    assign timerInc = timer_q + 1'b1;

    // Rotate the mask so bit 0 is the sensor right after the pointer; the lowest set bit wins.
    always_comb begin
        maskRot   = N_SENSORS'({i_sensor_mask, i_sensor_mask} >> ({1'b0, ptr_q} + 1'b1));
        pickFound = 1'b0;
        pickSum   = 0;
        pickIdx   = '0;
        for (int j = int'(N_SENSORS) - 1; j >= 0; j--) begin
            if (maskRot[j]) begin
                pickFound = 1'b1;
                pickSum   = int'(ptr_q) + 1 + j;
            end
        end
        if (pickSum >= int'(N_SENSORS)) begin
            pickSum = pickSum - int'(N_SENSORS);
        end
        pickIdx = IDW'(pickSum);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        ticks_d     = ticks_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        valid_d     = 1'b0;
        sensorId_d  = sensorId_q;
        edgeTicks_d = edgeTicks_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable && pickFound) begin
                    sel_d   = pickIdx;
                    ptr_d   = pickIdx;
                    cnt_d   = '0;
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    timer_d = '0;
                    state_d = ST_WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                timer_d = timerInc;
                if (timerInc == TMO_LIMIT) begin
                    valid_d     = 1'b1;
                    timeout_d   = 1'b1;
                    edgeTicks_d = '1;
                    sensorId_d  = sel_q;
                    cnt_d       = '0;
                    state_d     = ST_GUARD;
                end else if (echoRise) begin
                    // The rising sample is itself the first high tick of the echo.
                    ticks_d = TMO_WL'(1);
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!echoSel) begin
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    edgeTicks_d = O_WL'(ticks_q);
                    sensorId_d  = sel_q;
                    cnt_d       = '0;
                    state_d     = ST_GUARD;
                end else begin
                    timer_d = timerInc;
                    ticks_d = ticks_q + 1'b1;
                    if (timerInc == TMO_LIMIT) begin
                        valid_d     = 1'b1;
                        timeout_d   = 1'b1;
                        edgeTicks_d = '1;
                        sensorId_d  = sel_q;
                        cnt_d       = '0;
                        state_d     = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Trigger is registered from the next state so it is high exactly while the FSM sits in TRIG.
        trig_d = '0;
        if (state_d == ST_TRIG) begin
            trig_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            ticks_q     <= '0;
            sel_q       <= '0;
            ptr_q       <= IDW'(N_SENSORS - 1);
            trig_q      <= '0;
            valid_q     <= 1'b0;
            sensorId_q  <= '0;
            edgeTicks_q <= '0;
            timeout_q   <= 1'b0;
            echoMeta_q  <= '0;
            echoSync_q  <= '0;
            echoPrev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            ticks_q     <= ticks_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            sensorId_q  <= sensorId_d;
            edgeTicks_q <= edgeTicks_d;
            timeout_q   <= timeout_d;
            echoMeta_q  <= sn_echo;
            echoSync_q  <= echoMeta_q;
            echoPrev_q  <= echoSel;
        end
    end

    assign sn_trigger   = trig_q;
    assign o_valid      = valid_q;
    assign o_sensor_id  = sensorId_q;
    assign o_edge_ticks = edgeTicks_q;
    assign o_timeout    = timeout_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hc_sr04_ping_scheduler.sv
// Scoreboard bench for hc_sr04_ping_scheduler: a sensor echo model answers triggers, expected results
// are queued by the directed tests and a decoupled monitor pops and compares on every o_valid.
module tb_hc_sr04_ping_scheduler;

    localparam int N        = 4;
    localparam int TRIG     = 10;
    localparam int TMO      = 100;
    localparam int GUARD    = 20;
    localparam int ECHO_DLY = 5;
    localparam int ECHO_W   = 40;
    localparam int EXP_GAP  = ECHO_DLY + ECHO_W + 3 + GUARD + 1;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] ticks;
        logic        tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  mask;
    logic [N-1:0]  sn_trigger;
    logic [N-1:0]  echoPins;
    logic          o_valid;
    logic [1:0]    o_sensor_id;
    logic [31:0]   o_edge_ticks;
    logic          o_timeout;
    logic          o_busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rxCount    = 0;
    exp_t expQ[$];

    int       cfgWidth[N];
    bit       xtalkOn;
    int       startIn[N];
    int       highLeft[N];
    int       pendWidth[N];
    bit       pend[N];
    bit       on[N];
    int       echoFallCyc[N];
    int       trigFallCyc[N];
    logic [N-1:0] trigAllowed;
    bit       gapCheck;

    hc_sr04_ping_scheduler #(
        .CLK_FREQ(1000000), .N_SENSORS(N), .TRIG_DURATION_US(TRIG),
        .ECHO_TIMEOUT_US(TMO), .GUARD_US(GUARD), .O_WL(32)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(enable), .i_sensor_mask(mask),
        .sn_trigger(sn_trigger), .sn_echo(echoPins), .o_valid(o_valid),
        .o_sensor_id(o_sensor_id), .o_edge_ticks(o_edge_ticks),
        .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flagTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input logic en, input logic [N-1:0] m);
        enable = en;
        mask   = m;
    endtask

    task automatic pushExp(input int id, input bit tmo);
        exp_t e;
        e.id    = 2'(id);
        e.tmo   = tmo;
        e.ticks = tmo ? 32'hFFFF_FFFF : 32'(ECHO_W);
        expQ.push_back(e);
    endtask

    task automatic waitResults(input int target, input int budget);
        for (int c = 0; c < budget && rxCount < target; c++) @(negedge clk);
        if (rxCount < target) flagTimeout("resultWait");
    endtask

    task automatic waitTrigger(output logic [N-1:0] seen);
        seen = '0;
        for (int c = 0; c < 500 && seen == '0; c++) begin
            @(negedge clk);
            seen = sn_trigger;
        end
        if (seen == '0) flagTimeout("triggerWait");
    endtask

    task automatic stopAndDrain(input string name);
        enable = 1'b0;
        for (int c = 0; c < 300 && o_busy; c++) @(negedge clk);
        checkOutput({name, "_busyAfterStop"}, o_busy, 0);
        repeat (100) @(negedge clk);
        checkOutput({name, "_queueDrained"}, expQ.size(), 0);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic schedule(input int i, input int dly, input int w);
        pend[i]      = 1'b1;
        startIn[i]   = dly;
        pendWidth[i] = w;
    endtask

    // Sensor model: a falling trigger starts an echo of configured width after a fixed delay.
    initial begin
        logic [N-1:0] prevT;
        prevT    = '0;
        echoPins = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; on[i] = 0; startIn[i] = 0; highLeft[i] = 0; pendWidth[i] = 0;
            echoFallCyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (on[i]) begin
                    highLeft[i]--;
                    if (highLeft[i] == 0) begin
                        echoPins[i]    = 1'b0;
                        on[i]          = 1'b0;
                        echoFallCyc[i] = cyc;
                    end
                end else if (pend[i]) begin
                    startIn[i]--;
                    if (startIn[i] == 0) begin
                        echoPins[i] = 1'b1;
                        on[i]       = 1'b1;
                        highLeft[i] = pendWidth[i];
                        pend[i]     = 1'b0;
                    end
                end
            end
            if (!reset) begin
                for (int i = 0; i < N; i++) begin
                    if (prevT[i] && !sn_trigger[i]) begin
                        if (cfgWidth[i] > 0) schedule(i, ECHO_DLY, cfgWidth[i]);
                        if (xtalkOn && i == 0) schedule(2, 2, 70);
                    end
                end
            end
            prevT = sn_trigger;
        end
    end

    // Trigger monitor: one-hot, allowed sensor, exact width and the quiet gap between pings.
    initial begin
        logic [N-1:0] prevT, t;
        int runLen, lastFallCyc;
        bit lastFallValid;
        prevT = '0; runLen = 0; lastFallCyc = 0; lastFallValid = 0;
        for (int i = 0; i < N; i++) trigFallCyc[i] = 0;
        forever begin
            @(negedge clk);
            t = sn_trigger;
            if (t != '0 && prevT == '0) begin
                checkOutput("trigOneHot", $onehot(t), 1);
                checkOutput("trigAllowedSensor", t & ~trigAllowed, 0);
                if (gapCheck && lastFallValid) checkOutput("trigGap", cyc - lastFallCyc, EXP_GAP);
                runLen = 1;
            end else if (t != '0) begin
                runLen++;
                if (t != prevT) checkOutput("trigStable", t, prevT);
            end else if (prevT != '0) begin
                if (reset) begin
                    lastFallValid = 0;
                end else begin
                    checkOutput("trigWidth", runLen, TRIG);
                    for (int i = 0; i < N; i++) if (prevT[i]) trigFallCyc[i] = cyc;
                    lastFallCyc   = cyc;
                    lastFallValid = 1;
                end
            end
            prevT = t;
        end
    end

    // Result monitor: pops the scoreboard on each strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                rxCount++;
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedValid: got id %0d ticks %0h, expected no result", o_sensor_id, o_edge_ticks);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resultId", o_sensor_id, e.id);
                    checkOutput("resultTicks", o_edge_ticks, e.ticks);
                    checkOutput("resultTimeout", o_timeout, e.tmo);
                    if (e.tmo) checkOutput("timeoutLatency", cyc - trigFallCyc[e.id], TMO);
                    else       checkOutput("echoLatency", cyc - echoFallCyc[e.id], 3);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] seen;
        int base;
        reset = 1'b1; enable = 1'b0; mask = '0;
        xtalkOn = 0; gapCheck = 0; trigAllowed = '1;
        for (int i = 0; i < N; i++) cfgWidth[i] = ECHO_W;
        repeat (3) @(negedge clk);
        checkOutput("resetTrigger", sn_trigger, 0);
        checkOutput("resetValid", o_valid, 0);
        checkOutput("resetId", o_sensor_id, 0);
        checkOutput("resetTicks", o_edge_ticks, 0);
        checkOutput("resetTimeout", o_timeout, 0);
        checkOutput("resetBusy", o_busy, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: all sensors, round robin");
        gapCheck = 1;
        base = rxCount;
        pushExp(0, 0); pushExp(1, 0); pushExp(2, 0); pushExp(3, 0); pushExp(0, 0);
        applyStimulus(1'b1, 4'b1111);
        waitResults(base + 5, 1000);
        enable = 1'b0; gapCheck = 0;
        stopAndDrain("t1");

        $display("[TB] test 2: mask 1010");
        pulseReset();
        trigAllowed = 4'b1010;
        base = rxCount;
        pushExp(1, 0); pushExp(3, 0); pushExp(1, 0); pushExp(3, 0);
        applyStimulus(1'b1, 4'b1010);
        waitResults(base + 4, 800);
        stopAndDrain("t2");

        $display("[TB] test 3: silent sensor 2 times out");
        pulseReset();
        trigAllowed = 4'b1111;
        cfgWidth[2] = 0;
        base = rxCount;
        pushExp(0, 0); pushExp(1, 0); pushExp(2, 1); pushExp(3, 0);
        applyStimulus(1'b1, 4'b1111);
        waitResults(base + 4, 1000);
        stopAndDrain("t3");
        cfgWidth[2] = ECHO_W;

        $display("[TB] test 4: crosstalk on unselected sensor, single sensor repeated");
        pulseReset();
        trigAllowed = 4'b0001;
        xtalkOn = 1;
        base = rxCount;
        pushExp(0, 0); pushExp(0, 0); pushExp(0, 0);
        applyStimulus(1'b1, 4'b0001);
        waitResults(base + 3, 800);
        stopAndDrain("t4");
        xtalkOn = 0;

        $display("[TB] test 5: reset during trigger");
        pulseReset();
        trigAllowed = 4'b1111;
        applyStimulus(1'b1, 4'b1111);
        waitTrigger(seen);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetTrigger", sn_trigger, 0);
        checkOutput("midResetBusy", o_busy, 0);
        @(negedge clk);
        base = rxCount;
        pushExp(0, 0); pushExp(1, 0);
        reset = 1'b0;
        waitTrigger(seen);
        checkOutput("restartSensor", seen, 4'b0001);
        waitResults(base + 2, 600);
        stopAndDrain("t5");

        $display("[TB] test 6: enable dropped during measurement");
        pulseReset();
        base = rxCount;
        pushExp(0, 0);
        applyStimulus(1'b1, 4'b1111);
        for (int c = 0; c < 300 && !echoPins[0]; c++) @(negedge clk);
        if (!echoPins[0]) flagTimeout("echoWait");
        repeat (6) @(negedge clk);
        enable = 1'b0;
        trigAllowed = 4'b0000;
        waitResults(base + 1, 300);
        stopAndDrain("t6");

        $display("[TB] test 7: empty mask stays idle");
        pulseReset();
        applyStimulus(1'b1, 4'b0000);
        repeat (60) @(negedge clk);
        checkOutput("emptyMaskBusy", o_busy, 0);
        checkOutput("emptyMaskTrigger", sn_trigger, 0);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
